// File: rtl/axis_differentiator_pkg.sv
// Shared helpers for the lag differentiator: saturation, lag clamping, pointer sizing.
package axis_differentiator_pkg;

  localparam int MAX_LAG_DEFAULT = 16;
  localparam int PTR_WIDTH       = $clog2(MAX_LAG_DEFAULT);

  // Clamp a signed value carried at in_w bits into the out_w range; wider outputs pass through.
  function automatic logic signed [63:0] sat_signed(
    input logic signed [63:0] value,
    input int                 in_w,
    input int                 out_w
  );
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    if (out_w >= in_w) return value;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

  // A lag of zero means "previous sample"; anything past the line depth uses the full depth.
  function automatic int unsigned clamp_lag(
    input int unsigned lag,
    input int unsigned max_lag
  );
    if (lag == 0) return 1;
    if (lag > max_lag) return max_lag;
    return lag;
  endfunction

endpackage

// File: rtl/lag_delay_line.sv
// Circular sample history with one lag-offset asynchronous read and a saturating fill count.
module lag_delay_line
  import axis_differentiator_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int LAG_W  = $clog2(DEPTH) + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic [LAG_W-1:0]  i_lag,
  input  logic              i_restart,
  input  logic              i_hold_zero,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_primed
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [LAG_W-1:0]  r_fill;
  logic [LAG_W-1:0]  w_fill_base;
  logic [PW-1:0]     w_rd_addr;

  // A restart makes the incoming sample the first of a fresh priming run.
  assign w_fill_base = i_restart ? '0 : r_fill;
  assign o_primed    = (w_fill_base >= i_lag);

  // lag == DEPTH lands on wr_ptr itself, i.e. the oldest entry, read before it is overwritten.
  assign w_rd_addr = r_wr_ptr - i_lag[PW-1:0];
  assign o_rd_data = r_mem[w_rd_addr];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) r_mem[r_wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (i_wr_en) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_hold_zero)                      r_fill <= '0;
      else if (w_fill_base != LAG_W'(DEPTH)) r_fill <= w_fill_base + 1'b1;
      else                                   r_fill <= w_fill_base;
    end
  end

endmodule

// File: rtl/axis_lag_differentiator.sv
// y[n] = x[n] - x[n-L] on an AXI4-Stream with runtime lag, backpressure and output saturation.
module axis_lag_differentiator
  import axis_differentiator_pkg::*;
#(
  parameter int S_AXIS_TDATA_WIDTH = 32,
  parameter int M_AXIS_TDATA_WIDTH = 32,
  parameter int MAX_LAG            = 16,
  parameter int LAG_WIDTH          = $clog2(MAX_LAG) + 1
) (
  input  logic                          aclk,
  input  logic                          aresetn,
  input  logic                          enable,
  input  logic [LAG_WIDTH-1:0]          lag,
  input  logic [S_AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                          S_AXIS_tvalid,
  output logic                          S_AXIS_tready,
  output logic [M_AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready
);

  localparam int SW = S_AXIS_TDATA_WIDTH;
  localparam int MW = M_AXIS_TDATA_WIDTH;

  logic [LAG_WIDTH-1:0] r_lag_q;
  logic [MW-1:0]        r_tdata;
  logic                 r_tvalid;

  logic                 w_accept;
  logic [LAG_WIDTH-1:0] w_l_eff;
  logic                 w_lag_chg;
  logic [SW-1:0]        w_x_old;
  logic                 w_primed;
  logic signed [SW:0]   w_diff;
  logic [MW-1:0]        w_y_sat;
  logic [MW-1:0]        w_y;

  assign S_AXIS_tready = !r_tvalid || M_AXIS_tready;
  assign w_accept      = S_AXIS_tvalid && S_AXIS_tready;
  assign w_l_eff       = LAG_WIDTH'(clamp_lag(32'(lag), MAX_LAG));
  assign w_lag_chg     = (w_l_eff != r_lag_q);

  lag_delay_line #(
    .DATA_W (SW),
    .DEPTH  (MAX_LAG),
    .LAG_W  (LAG_WIDTH)
  ) u_line (
    .i_clk       (aclk),
    .i_rst_n     (aresetn),
    .i_wr_en     (w_accept),
    .i_wr_data   (S_AXIS_tdata),
    .i_lag       (w_l_eff),
    .i_restart   (w_lag_chg),
    .i_hold_zero (!enable),
    .o_rd_data   (w_x_old),
    .o_primed    (w_primed)
  );

  // One guard bit makes the subtraction exact for any pair of inputs.
  assign w_diff  = {S_AXIS_tdata[SW-1], S_AXIS_tdata} - {w_x_old[SW-1], w_x_old};
  assign w_y_sat = MW'(sat_signed(64'(w_diff), SW + 1, MW));
  assign w_y     = (enable && w_primed) ? w_y_sat : '0;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_lag_q  <= LAG_WIDTH'(1);
      r_tdata  <= '0;
      r_tvalid <= 1'b0;
    end else if (w_accept) begin
      r_lag_q  <= w_l_eff;
      r_tdata  <= w_y;
      r_tvalid <= 1'b1;
    end else if (M_AXIS_tready) begin
      r_tvalid <= 1'b0;
    end
  end

  assign M_AXIS_tdata  = r_tdata;
  assign M_AXIS_tvalid = r_tvalid;

endmodule

// File: tb/tb_axis_lag_differentiator.sv
// Directed + randomized scoreboard bench for axis_lag_differentiator at 16-bit in/out.
module tb_axis_lag_differentiator;

  localparam int SW = 16;
  localparam int MW = 16;
  localparam int ML = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          aresetn = 1'b0;
  logic          enable = 1'b1;
  logic [LW-1:0] lag = 5'd1;
  logic [SW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [MW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready = 1'b1;

  int checks = 0;
  int failures = 0;
  int tr_mode = 0;  // 0: ready, 1: random, 2: held low

  logic [MW-1:0] sb_q[$];
  int            out_log[$];
  int            exp_log[$];
  int            hist[$];
  int            m_lag = 1;
  int            m_fill = 0;
  logic          acc_seen = 1'b0;
  logic          prev_stall = 1'b0;
  logic [MW-1:0] prev_data = '0;

  axis_lag_differentiator #(
    .S_AXIS_TDATA_WIDTH (SW),
    .M_AXIS_TDATA_WIDTH (MW),
    .MAX_LAG            (ML),
    .LAG_WIDTH          (LW)
  ) dut (
    .aclk          (clk),
    .aresetn       (aresetn),
    .enable        (enable),
    .lag           (lag),
    .S_AXIS_tdata  (s_tdata),
    .S_AXIS_tvalid (s_tvalid),
    .S_AXIS_tready (s_tready),
    .M_AXIS_tdata  (m_tdata),
    .M_AXIS_tvalid (m_tvalid),
    .M_AXIS_tready (m_tready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    end
  endtask

  // Golden behaviour for one accepted sample.
  task automatic model_accept(input logic [SW-1:0] xin);
    int leff, x, d;
    leff = (lag == 0) ? 1 : ((int'(lag) > ML) ? ML : int'(lag));
    if (leff != m_lag) begin
      m_lag  = leff;
      m_fill = 0;
    end
    x = int'($signed(xin));
    d = 0;
    if (enable && m_fill >= leff && hist.size() >= leff) begin
      d = x - hist[leff-1];
      if (d > 32767) d = 32767;
      if (d < -32768) d = -32768;
    end
    m_fill = !enable ? 0 : ((m_fill < ML) ? m_fill + 1 : ML);
    hist.push_front(x);
    if (hist.size() > ML) void'(hist.pop_back());
    sb_q.push_back(MW'(d));
  endtask

  // Observe the cycle about to complete (inputs are stable since the last posedge).
  task automatic monitor();
    logic [MW-1:0] e;
    if (!aresetn) begin
      m_fill = 0;
      m_lag = 1;
      sb_q.delete();
      prev_stall = 1'b0;
      acc_seen = 1'b0;
      return;
    end
    if (prev_stall) begin
      chk("stall_valid", 32'(m_tvalid), 32'd1);
      chk("stall_data", 32'(m_tdata), 32'(prev_data));
    end
    if (m_tvalid && m_tready) begin
      if (sb_q.size() == 0) begin
        chk("extra_output", 32'(sb_q.size()), 32'd1);
      end else begin
        e = sb_q.pop_front();
        chk("out_data", 32'(m_tdata), 32'(e));
        out_log.push_back(int'($signed(m_tdata)));
      end
    end
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
    acc_seen   = s_tvalid && s_tready;
    if (acc_seen) model_accept(s_tdata);
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    case (tr_mode)
      1:       m_tready = 1'($urandom_range(0, 1));
      2:       m_tready = 1'b0;
      default: m_tready = 1'b1;
    endcase
  endtask

  task automatic send(input logic [SW-1:0] x);
    int n;
    s_tdata  = x;
    s_tvalid = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (!acc_seen && n < 200);
    if (!acc_seen) chk("send_timeout", 32'(acc_seen), 32'd1);
    s_tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && sb_q.size() != 0; i++) tick();
    chk("drain_empty", 32'(sb_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    tick();
    aresetn = 1'b1;
    out_log.delete();
  endtask

  task automatic check_log(input string tag);
    chk({tag, "_len"}, 32'(out_log.size()), 32'(exp_log.size()));
    for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
      chk(tag, 32'(out_log[i]), 32'(exp_log[i]));
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", 32'(m_tdata), 32'd0);
    chk("rst_tready", 32'(s_tready), 32'd1);

    // 1) L=1 ramp, one-cycle latency
    lag = 5'd1;
    send(16'd0);
    chk("latency_valid", 32'(m_tvalid), 32'd1);
    for (int n = 1; n < 8; n++) send(SW'(3 * n));
    drain();
    exp_log = '{0, 3, 3, 3, 3, 3, 3, 3};
    check_log("ramp_l1");

    // 2) L=4 squares
    do_reset();
    lag = 5'd4;
    for (int n = 0; n < 10; n++) send(SW'(n * n));
    drain();
    exp_log = '{0, 0, 0, 0, 16, 24, 32, 40, 48, 56};
    check_log("sq_l4");

    // 3) saturation at both rails
    do_reset();
    lag = 5'd1;
    send(16'h8000);
    send(16'h7fff);
    send(16'h8000);
    drain();
    exp_log = '{0, 32767, -32768};
    check_log("sat");

    // 5) lag change 2->8, lag=0 as 1, lag=31 as 16 and no re-prime on 31->16
    do_reset();
    lag = 5'd2;
    for (int n = 0; n < 4; n++) send(SW'(5 * n));
    lag = 5'd8;
    for (int n = 4; n < 14; n++) send(SW'(5 * n));
    drain();
    exp_log = '{0, 0, 10, 10, 0, 0, 0, 0, 0, 0, 0, 0, 40, 40};
    check_log("lag_2_8");

    do_reset();
    lag = 5'd0;
    for (int n = 0; n < 3; n++) send(SW'(3 * n));
    drain();
    exp_log = '{0, 3, 3};
    check_log("lag0");

    do_reset();
    lag = 5'd31;
    for (int n = 0; n < 18; n++) send(SW'(n));
    lag = 5'd16;
    send(SW'(18));
    drain();
    exp_log = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16, 16, 16};
    check_log("lag31");

    // 6a) enable low for 5 samples, then re-prime
    do_reset();
    lag = 5'd2;
    enable = 1'b1;
    for (int n = 0; n < 3; n++) send(SW'(10 * n));
    enable = 1'b0;
    for (int n = 3; n < 8; n++) send(SW'(10 * n));
    enable = 1'b1;
    for (int n = 8; n < 13; n++) send(SW'(10 * n));
    drain();
    exp_log = '{0, 0, 20, 0, 0, 0, 0, 0, 0, 0, 20, 20, 20};
    check_log("enable");

    // 6b) reset with a stalled output pending
    lag = 5'd1;
    send(16'd100);
    send(16'd107);
    tr_mode = 2;
    send(16'd120);
    tick();
    chk("stalled_valid", 32'(m_tvalid), 32'd1);
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
    tr_mode = 0;
    m_tready = 1'b1;
    chk("midrst_tvalid", 32'(m_tvalid), 32'd0);
    chk("midrst_tdata", 32'(m_tdata), 32'd0);
    out_log.delete();
    send(16'd50);
    send(16'd58);
    drain();
    exp_log = '{0, 8};
    check_log("post_rst");

    // 4) random backpressure, bursty source, occasional lag changes
    do_reset();
    lag = 5'd3;
    tr_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      if (i % 250 == 125) lag = LW'($urandom_range(0, 31));
      send(SW'($urandom));
      if (i % 2 == 1) begin
        tick();
        tick();
      end
    end
    drain();
    tr_mode = 0;
    chk("rand_count", 32'(out_log.size()), 32'd1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
